// File: rtl/wavelet_result_scheduler_pkg.sv
// Shared types and defaults for the wavelet result scheduler.
// WAVELET_SCHED_TIMESTAMP_EN adds per-result sample stamps.
package wavelet_pkg;

  localparam int NUM_FILTERS_DEFAULT = 8;
  localparam int RESULT_BITS_DEFAULT = 16;
  localparam int DIV_WIDTH_DEFAULT   = 4;
  localparam int STAMP_BITS          = 16;

  function automatic int chan_bits(input int n);
    return $clog2(n);
  endfunction

  localparam int CHAN_BITS = chan_bits(NUM_FILTERS_DEFAULT);

  typedef enum logic {
    IDLE,
    OFFER
  } state_t;

endpackage

// File: rtl/wavelet_result_scheduler_if.sv
// Bus bundle between the scheduler (master) and the filter bank / readout (slave).
// WAVELET_SCHED_TIMESTAMP_EN adds the stamp signal.
interface wavelet_result_scheduler_if
  import wavelet_pkg::*;
#(
  parameter int NUM_FILTERS = NUM_FILTERS_DEFAULT,
  parameter int RESULT_BITS = RESULT_BITS_DEFAULT,
  parameter int DIV_WIDTH   = DIV_WIDTH_DEFAULT
);
  localparam int CB = chan_bits(NUM_FILTERS);

  logic [DIV_WIDTH-1:0]               sample_div;
  logic                               sample_en;
  logic [NUM_FILTERS-1:0]             fir_valid;
  logic [NUM_FILTERS*RESULT_BITS-1:0] fir_data;
  logic                               valid;
  logic                               ready;
  logic [RESULT_BITS-1:0]             data;
  logic [CB-1:0]                      chan;
  logic [NUM_FILTERS-1:0]             overrun;
  logic                               clr_overrun;
`ifdef WAVELET_SCHED_TIMESTAMP_EN
  logic [STAMP_BITS-1:0]              stamp;
`endif

  modport master (
    input  sample_div, fir_valid, fir_data, ready, clr_overrun,
`ifdef WAVELET_SCHED_TIMESTAMP_EN
    output stamp,
`endif
    output sample_en, valid, data, chan, overrun
  );

  modport slave (
    output sample_div, fir_valid, fir_data, ready, clr_overrun,
`ifdef WAVELET_SCHED_TIMESTAMP_EN
    input  stamp,
`endif
    input  sample_en, valid, data, chan, overrun
  );

endinterface

// File: rtl/wavelet_result_scheduler_rr_pick.sv
// Combinational round-robin find-first: first set bit of pending at or above ptr, modulo N.
module wavelet_rr_pick #(
  parameter int N  = 8,
  parameter int CW = 3
) (
  input  logic [N-1:0]  pending,
  input  logic [CW-1:0] ptr,
  output logic          any,
  output logic [CW-1:0] grant
);

  logic [CW-1:0] idx;

  // Walk downward so the smallest offset from ptr is the last to write grant.
  always_comb begin
    any   = |pending;
    grant = '0;
    idx   = '0;
    for (int i = N - 1; i >= 0; i--) begin
      idx = CW'((int'(ptr) + i) % N);
      if (pending[idx]) grant = idx;
    end
  end

endmodule

// File: rtl/wavelet_result_scheduler.sv
// Sample-enable divider, per-band result capture and round-robin valid/ready serializer.
// Optional WAVELET_SCHED_TIMESTAMP_EN stamps each captured result with a sample count.
module wavelet_result_scheduler
  import wavelet_pkg::*;
#(
  parameter int NUM_FILTERS = NUM_FILTERS_DEFAULT,
  parameter int RESULT_BITS = RESULT_BITS_DEFAULT,
  parameter int DIV_WIDTH   = DIV_WIDTH_DEFAULT
) (
  input logic                        clk,
  input logic                        rst_n,
  wavelet_result_scheduler_if.master bus
);
  localparam int CB = chan_bits(NUM_FILTERS);

  logic [DIV_WIDTH-1:0]   div_count;
  state_t                 state;
  logic [NUM_FILTERS-1:0] pending;
  logic [CB-1:0]          ptr;
  logic [RESULT_BITS-1:0] slot [NUM_FILTERS];
  logic                   pick_any;
  logic [CB-1:0]          pick_grant;
  logic                   do_grant;
  logic [NUM_FILTERS-1:0] grant_mask;
  logic [NUM_FILTERS-1:0] new_overrun;

  wavelet_rr_pick #(.N(NUM_FILTERS), .CW(CB)) u_pick (
    .pending (pending),
    .ptr     (ptr),
    .any     (pick_any),
    .grant   (pick_grant)
  );

  // A grant happens from IDLE, or in OFFER only on the handshake edge.
  always_comb begin
    do_grant   = pick_any && ((state == IDLE) || bus.ready);
    grant_mask = '0;
    if (do_grant) grant_mask[pick_grant] = 1'b1;
    new_overrun = bus.fir_valid & pending & ~grant_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_count     <= '0;
      bus.sample_en <= 1'b0;
    end else if (div_count == bus.sample_div) begin
      div_count     <= '0;
      bus.sample_en <= 1'b1;
    end else if (div_count > bus.sample_div) begin
      div_count     <= '0;
      bus.sample_en <= 1'b0;
    end else begin
      div_count     <= div_count + 1'b1;
      bus.sample_en <= 1'b0;
    end
  end

`ifdef WAVELET_SCHED_TIMESTAMP_EN
  logic [STAMP_BITS-1:0] stamp_count;
  logic [STAMP_BITS-1:0] slot_stamp [NUM_FILTERS];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stamp_count <= '0;
    else if (bus.sample_en) stamp_count <= stamp_count + 1'b1;
  end
`endif

  // A capture on the granted band keeps pending set: the old word leaves, the new one waits.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending     <= '0;
      bus.overrun <= '0;
      for (int k = 0; k < NUM_FILTERS; k++) begin
        slot[k] <= '0;
`ifdef WAVELET_SCHED_TIMESTAMP_EN
        slot_stamp[k] <= '0;
`endif
      end
    end else begin
      for (int k = 0; k < NUM_FILTERS; k++) begin
        if (bus.fir_valid[k]) begin
          slot[k]    <= bus.fir_data[k*RESULT_BITS +: RESULT_BITS];
`ifdef WAVELET_SCHED_TIMESTAMP_EN
          slot_stamp[k] <= stamp_count;
`endif
          pending[k] <= 1'b1;
        end else if (grant_mask[k]) begin
          pending[k] <= 1'b0;
        end
      end
      bus.overrun <= bus.clr_overrun ? new_overrun : (bus.overrun | new_overrun);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ptr       <= '0;
      bus.valid <= 1'b0;
      bus.data  <= '0;
      bus.chan  <= '0;
`ifdef WAVELET_SCHED_TIMESTAMP_EN
      bus.stamp <= '0;
`endif
    end else if (do_grant) begin
      state     <= OFFER;
      bus.valid <= 1'b1;
      bus.data  <= slot[pick_grant];
      bus.chan  <= pick_grant;
`ifdef WAVELET_SCHED_TIMESTAMP_EN
      bus.stamp <= slot_stamp[pick_grant];
`endif
      ptr <= (pick_grant == CB'(NUM_FILTERS - 1)) ? '0 : pick_grant + 1'b1;
    end else if (state == OFFER && bus.ready) begin
      state     <= IDLE;
      bus.valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_wavelet_result_scheduler.sv
// Scoreboard bench for wavelet_result_scheduler; checks stamps when WAVELET_SCHED_TIMESTAMP_EN is set.
module tb_wavelet_result_scheduler;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  typedef struct {
    logic [2:0]  chan;
    logic [15:0] data;
    logic [15:0] stamp;
  } exp_t;

  exp_t expq[$];

  wavelet_result_scheduler_if #(.NUM_FILTERS(8), .RESULT_BITS(16), .DIV_WIDTH(4)) bus ();

  wavelet_result_scheduler #(.NUM_FILTERS(8), .RESULT_BITS(16), .DIV_WIDTH(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference divider and sample counter used for strobe and stamp expectations.
  logic [3:0]  m_cnt;
  logic        m_en;
  logic [15:0] m_stamp;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_cnt   <= '0;
      m_en    <= 1'b0;
      m_stamp <= '0;
    end else begin
      if (m_en) m_stamp <= m_stamp + 16'd1;
      if (m_cnt == bus.sample_div) begin
        m_cnt <= '0;
        m_en  <= 1'b1;
      end else if (m_cnt > bus.sample_div) begin
        m_cnt <= '0;
        m_en  <= 1'b0;
      end else begin
        m_cnt <= m_cnt + 4'd1;
        m_en  <= 1'b0;
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    checks++;
    if (actual !== required) begin
      failures++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, required);
    end
  endtask

  task automatic pushExp(input logic [2:0] chan, input logic [15:0] data);
    exp_t e;
    e.chan  = chan;
    e.data  = data;
    e.stamp = m_stamp;
    expq.push_back(e);
  endtask

  // Drives one cycle of band strobes; every masked band gets the same word.
  task automatic applyStimulus(input logic [7:0] vmask, input logic [15:0] word);
    bus.fir_valid = vmask;
    for (int k = 0; k < 8; k++) bus.fir_data[k*16 +: 16] = word;
    @(posedge clk);
    #1;
    bus.fir_valid = '0;
  endtask

  task automatic waitValid(input int budget);
    int n = 0;
    while (!bus.valid && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("wait_valid", 32'(bus.valid), 32'd1);
  endtask

  task automatic waitDrain(input int budget);
    int n = 0;
    while (expq.size() != 0 && n < budget) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("drain", 32'(expq.size()), 32'd0);
  endtask

  // Monitor: pops the scoreboard on each handshake and checks stall stability.
  logic        stall_seen;
  logic [15:0] held_data;
  logic [2:0]  held_chan;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      stall_seen = 1'b0;
    end else begin
      checkOutput("sample_en_model", 32'(bus.sample_en), 32'(m_en));
      if (bus.valid && stall_seen) begin
        checkOutput("hold_data", 32'(bus.data), 32'(held_data));
        checkOutput("hold_chan", 32'(bus.chan), 32'(held_chan));
      end
      if (bus.valid && bus.ready) begin
        if (expq.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_word actual chan=%0d data=%h required none", bus.chan, bus.data);
        end else begin
          e = expq.pop_front();
          checkOutput("word_chan", 32'(bus.chan), 32'(e.chan));
          checkOutput("word_data", 32'(bus.data), 32'(e.data));
`ifdef WAVELET_SCHED_TIMESTAMP_EN
          checkOutput("word_stamp", 32'(bus.stamp), 32'(e.stamp));
`endif
        end
      end
      stall_seen = bus.valid && !bus.ready;
      held_data  = bus.data;
      held_chan  = bus.chan;
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    checks          = 0;
    failures        = 0;
    stall_seen      = 1'b0;
    rst_n           = 1'b0;
    bus.sample_div  = 4'd3;
    bus.fir_valid   = '0;
    bus.fir_data    = '0;
    bus.ready       = 1'b0;
    bus.clr_overrun = 1'b0;
    #2;
    checkOutput("rst_valid", 32'(bus.valid), 32'd0);
    checkOutput("rst_sample_en", 32'(bus.sample_en), 32'd0);
    checkOutput("rst_overrun", 32'(bus.overrun), 32'd0);
    checkOutput("rst_data", 32'(bus.data), 32'd0);
    #10 rst_n = 1'b1;

    // Divide by 4: strobe after edges 4 and 8.
    for (int i = 1; i <= 8; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("div3_edge%0d", i), 32'(bus.sample_en), 32'((i % 4) == 0));
    end
    bus.sample_div = 4'd0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      checkOutput("div0_strobe", 32'(bus.sample_en), 32'd1);
    end
    bus.sample_div = 4'd2;

    // Single band 5 result: valid two edges after the strobe, for one cycle.
    bus.ready = 1'b1;
    pushExp(3'd5, 16'h1234);
    applyStimulus(8'h20, 16'h1234);
    checkOutput("lat_t0_valid", 32'(bus.valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("lat_t1_valid", 32'(bus.valid), 32'd1);
    checkOutput("lat_t1_chan", 32'(bus.chan), 32'd5);
    checkOutput("lat_t1_data", 32'(bus.data), 32'h1234);
    @(posedge clk);
    #1;
    checkOutput("lat_t2_valid", 32'(bus.valid), 32'd0);

    // Fresh pointer, then bands 0/3/7 back-to-back and 0/3 after the wrap.
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    pushExp(3'd0, 16'h0C0C);
    pushExp(3'd3, 16'h0C0C);
    pushExp(3'd7, 16'h0C0C);
    applyStimulus(8'h89, 16'h0C0C);
    waitDrain(10);
    pushExp(3'd0, 16'h0D0D);
    pushExp(3'd3, 16'h0D0D);
    applyStimulus(8'h09, 16'h0D0D);
    waitDrain(10);

    // Stalled offer of band 2 while band 4 is overwritten.
    bus.ready = 1'b0;
    pushExp(3'd2, 16'h0202);
    applyStimulus(8'h04, 16'h0202);
    waitValid(5);
    applyStimulus(8'h10, 16'h4444);
    pushExp(3'd4, 16'h4445);
    applyStimulus(8'h10, 16'h4445);
    checkOutput("overrun_set", 32'(bus.overrun), 32'h10);
    repeat (3) @(posedge clk);
    #1;
    bus.ready = 1'b1;
    waitDrain(10);
    checkOutput("overrun_sticky", 32'(bus.overrun), 32'h10);
    bus.clr_overrun = 1'b1;
    @(posedge clk);
    #1;
    bus.clr_overrun = 1'b0;
    checkOutput("overrun_clear", 32'(bus.overrun), 32'h00);

    // Band 1 granted in the same edge it captures a newer word.
    pushExp(3'd1, 16'hAAAA);
    applyStimulus(8'h02, 16'hAAAA);
    pushExp(3'd1, 16'hBBBB);
    applyStimulus(8'h02, 16'hBBBB);
    waitDrain(10);
    checkOutput("coincident_overrun", 32'(bus.overrun), 32'h00);

    // Reset mid-offer with three bands still pending: nothing may reappear.
    bus.ready = 1'b0;
    applyStimulus(8'h0F, 16'h5A5A);
    waitValid(5);
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(bus.valid), 32'd0);
    checkOutput("midrst_data", 32'(bus.data), 32'd0);
    checkOutput("midrst_chan", 32'(bus.chan), 32'd0);
    checkOutput("midrst_sample_en", 32'(bus.sample_en), 32'd0);
    @(posedge clk);
    #1;
    rst_n     = 1'b1;
    bus.ready = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    checkOutput("post_rst_valid", 32'(bus.valid), 32'd0);
    checkOutput("post_rst_queue", 32'(expq.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
